// File: rtl/image_chunk_tx_pkg.sv
// Shared definitions for the image chunk transmitter: word width, default
// frame geometry, the chunk-count helper and the FSM state encoding.
package image_chunk_tx_pkg;

   localparam int WORD_W              = 32;
   localparam int DEFAULT_FRAME_BITS  = 800;
   localparam int DEFAULT_CHUNK_WORDS = 14;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      PRESENT,
      RELEASE,
      GAP
   } txState_t;

   // Number of chunks needed to carry a frame, rounding the last one up.
   function automatic int chunkCount(input int frameBits, input int chunkWords);
      return (frameBits + WORD_W * chunkWords - 1) / (WORD_W * chunkWords);
   endfunction

endpackage

// File: rtl/image_chunk_tx_mux.sv
// Chunk selector: picks the current chunk out of the latched frame and
// zero-fills every word slot that lies beyond the end of the frame.
module image_chunk_mux
   import image_chunk_tx_pkg::*;
#(
   parameter int FRAME_BITS  = DEFAULT_FRAME_BITS,
   parameter int CHUNK_WORDS = DEFAULT_CHUNK_WORDS,
   parameter int N_CHUNKS    = chunkCount(DEFAULT_FRAME_BITS, DEFAULT_CHUNK_WORDS),
   parameter int IDX_W       = 1
) (
   input  logic [FRAME_BITS-1:0]         frame,
   input  logic [IDX_W-1:0]              chunkIdx,
   output logic [WORD_W*CHUNK_WORDS-1:0] chunkData
);

   localparam int CHUNK_BITS = WORD_W * CHUNK_WORDS;
   localparam int PAD_BITS   = N_CHUNKS * CHUNK_BITS;

   logic [PAD_BITS-1:0] padded;

   // Extend the frame to a whole number of chunks with zeros on top.
   always_comb begin
      padded                   = '0;
      padded[FRAME_BITS-1:0]   = frame;
   end

   // Select the chunk addressed by the index; unused index codes give zero.
   always_comb begin
      chunkData = '0;
      for (int c = 0; c < N_CHUNKS; c++) begin
         if (chunkIdx == IDX_W'(c)) begin
            chunkData = padded[c*CHUNK_BITS +: CHUNK_BITS];
         end
      end
   end

endmodule

// File: rtl/image_chunk_tx.sv
// Image chunk transmitter: latches a frame on request and hands it to a
// receiver one chunk at a time over a four-phase NEXT/ACK handshake, with
// a programmable idle gap between chunks.
module image_chunk_tx
   import image_chunk_tx_pkg::*;
#(
   parameter int FRAME_BITS  = DEFAULT_FRAME_BITS,
   parameter int CHUNK_WORDS = DEFAULT_CHUNK_WORDS,
   parameter int GAP_CYCLES  = 2
) (
   input  logic                          iCLK,
   input  logic                          iRESET,
   input  logic                          iSTART,
   input  logic [FRAME_BITS-1:0]         iFRAME,
   input  logic                          iACK,
   output logic [WORD_W*CHUNK_WORDS-1:0] oDATA,
   output logic                          oNEXT,
   output logic                          oFINISH,
   output logic                          oBUSY,
   output logic                          oDONE
);

   localparam int N_CHUNKS = chunkCount(FRAME_BITS, CHUNK_WORDS);
   localparam int IDX_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

   txState_t              state;
   txState_t              nextState;
   logic [IDX_W-1:0]      chunkIdx;
   logic [3:0]            gapCnt;
   logic [FRAME_BITS-1:0] frameReg;
   logic                  nextReg;

   logic lastChunk;
   logic gapExpired;
   logic loadFrame;
   logic advanceChunk;
   logic loadGap;
   logic countGap;
   logic doneNow;

   assign lastChunk  = (chunkIdx == LAST_IDX);
   assign gapExpired = (gapCnt <= 4'd1);

   // Next-state and datapath control; the gap counter is loaded with the
   // gap length and the last gap cycle is the one where it holds 1, so the
   // gap lasts exactly GAP_CYCLES cycles.
   always_comb begin
      nextState    = state;
      loadFrame    = 1'b0;
      advanceChunk = 1'b0;
      loadGap      = 1'b0;
      countGap     = 1'b0;
      doneNow      = 1'b0;
      case (state)
         IDLE: begin
            if (iSTART) begin
               nextState = SETUP;
               loadFrame = 1'b1;
            end
         end
         SETUP: begin
            nextState = PRESENT;
         end
         PRESENT: begin
            if (iACK) begin
               nextState = RELEASE;
            end
         end
         RELEASE: begin
            if (!iACK) begin
               nextState = GAP;
               loadGap   = 1'b1;
            end
         end
         GAP: begin
            if (gapExpired) begin
               if (lastChunk) begin
                  nextState = IDLE;
                  doneNow   = 1'b1;
               end else begin
                  nextState    = SETUP;
                  advanceChunk = 1'b1;
               end
            end else begin
               countGap = 1'b1;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // State register plus a registered copy of "presenting" so oNEXT comes
   // straight from a flop and cannot glitch.
   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         state   <= IDLE;
         nextReg <= 1'b0;
      end else begin
         state   <= nextState;
         nextReg <= (nextState == PRESENT);
      end
   end

   // Frame latch, chunk index and gap counter; the frame is captured only
   // on an accepted start, so requests during a transfer leave it alone.
   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         frameReg <= '0;
         chunkIdx <= '0;
         gapCnt   <= '0;
      end else begin
         if (loadFrame) begin
            frameReg <= iFRAME;
            chunkIdx <= '0;
         end else if (advanceChunk) begin
            chunkIdx <= chunkIdx + IDX_W'(1);
         end
         if (loadGap) begin
            gapCnt <= 4'(GAP_CYCLES);
         end else if (countGap) begin
            gapCnt <= gapCnt - 4'd1;
         end
      end
   end

   image_chunk_mux #(
      .FRAME_BITS  (FRAME_BITS),
      .CHUNK_WORDS (CHUNK_WORDS),
      .N_CHUNKS    (N_CHUNKS),
      .IDX_W       (IDX_W)
   ) chunkMux (
      .frame     (frameReg),
      .chunkIdx  (chunkIdx),
      .chunkData (oDATA)
   );

   assign oNEXT   = nextReg;
   assign oBUSY   = (state != IDLE);
   assign oFINISH = oBUSY && lastChunk;
   assign oDONE   = doneNow;

endmodule

// File: doc/image_chunk_tx.md
IMAGE_CHUNK_TX -- requirements
Module: image_chunk_tx

Interface
REQ-001 Parameter FRAME_BITS, default 800: frame width in bits.
REQ-002 Parameter CHUNK_WORDS, default 14: 32-bit words per chunk.
REQ-003 Parameter GAP_CYCLES, default 2: minimum oNEXT-low cycles between chunks, range 1..15.
REQ-004 iCLK  in  1  single clock for the whole block; one clock; reset is asynchronous and active-high.
REQ-005 iRESET  in  1  asynchronous, active-high reset.
REQ-006 iSTART  in  1  one-cycle request to transmit iFRAME.
REQ-007 iFRAME  in  FRAME_BITS  frame to send, sampled only on an accepted iSTART.
REQ-008 iACK  in  1  receiver has captured the presented chunk, level.
REQ-009 oDATA  out  32*CHUNK_WORDS  chunk words, word i at bits [32*i +: 32].
REQ-010 oNEXT  out  1  chunk valid strobe, level.
REQ-011 oFINISH  out  1  marks presented chunk as final.
REQ-012 oBUSY  out  1  transfer in progress.
REQ-013 oDONE  out  1  one-cycle pulse, transfer complete.

Function
REQ-014 Chunk count SHALL be ceil(FRAME_BITS/(32*CHUNK_WORDS)); defaults give 2 chunks (14 + 11 words).
REQ-015 Chunk c, word i SHALL carry frame bits [448*c + 32*i +: 32] (defaults); slots past FRAME_BITS SHALL read 0 (chunk 1 words 11..13 = 0).
REQ-016 FSM states SHALL be IDLE, SETUP, PRESENT, RELEASE, GAP.
REQ-017 IDLE: iSTART=1 SHALL latch iFRAME, clear chunk index, go SETUP; oBUSY high from next cycle.
REQ-018 SETUP: oDATA and oFINISH SHALL be driven for the current chunk with oNEXT low, for exactly one cycle, then PRESENT.
REQ-019 PRESENT: oNEXT SHALL be 1; oDATA and oFINISH SHALL stay constant; on iACK=1, go RELEASE.
REQ-020 RELEASE: oNEXT SHALL be 0, oDATA/oFINISH held; stay until iACK=0, then go GAP with gap counter loaded to GAP_CYCLES.
REQ-021 GAP: oNEXT SHALL stay 0 until the counter reaches 0; then final chunk -> IDLE with oDONE=1 for one cycle; else increment chunk index -> SETUP.
REQ-022 oFINISH SHALL be 1 only during SETUP/PRESENT/RELEASE/GAP of the last chunk, and 0 in IDLE.
REQ-023 A single-chunk frame SHALL assert oFINISH on its only chunk.
REQ-024 iSTART while oBUSY=1 SHALL be ignored; the latched frame SHALL NOT change.
REQ-025 iACK in IDLE, SETUP or GAP SHALL be ignored. iACK already high on entry to PRESENT SHALL be accepted next cycle.
REQ-026 iSTART coincident with the oDONE cycle SHALL be ignored (block not yet IDLE).
REQ-027 Minimum per-chunk latency with iACK tied to oNEXT SHALL be 1 (SETUP) + 1 + 1 + GAP_CYCLES cycles.
REQ-028 oNEXT SHALL be registered and glitch-free; oNEXT rising edges SHALL equal the chunk count per transfer.

Reset
REQ-029 iRESET=1 SHALL asynchronously force IDLE, oNEXT=0, oFINISH=0, oBUSY=0, oDONE=0, oDATA=0, counters 0.
REQ-030 Reset mid-transfer SHALL abort it with no oDONE; the next iSTART after release SHALL send the full new frame from chunk 0.

Structure
REQ-031 Shared package SHALL hold WORD_W=32, default FRAME_BITS/CHUNK_WORDS, the chunk-count function and the FSM state enum.
REQ-032 One sub-module, image_chunk_mux (latched frame + chunk index -> oDATA words, zero-padded), SHALL be used; the FSM and counters stay in image_chunk_tx.

Verification
REQ-033 iFRAME word k = 32'h1000_0000+k, iSTART, iACK echoes oNEXT after 3 cycles -> two oNEXT pulses. Chunk 0 words = 1000_0000..1000_000D with oFINISH=0; chunk 1 = 1000_000E..1000_0018 then 0,0,0 with oFINISH=1; oDONE once.
REQ-034 Hold iACK=1 for 10 cycles after the first oNEXT -> oNEXT low by the cycle after the first iACK; the second chunk is not presented until 2 cycles after iACK falls.
REQ-035 Second iSTART with a different frame during chunk 0 -> ignored; chunk 1 carries the original frame data.
REQ-036 Assert iRESET during PRESENT of chunk 1 -> all outputs 0 asynchronously, no oDONE; a new iSTART sends chunk 0 correctly.
REQ-037 Check that oDATA and oFINISH are constant over every SETUP..RELEASE window, and that oNEXT-low between chunks is at least GAP_CYCLES+1 cycles.
